// File: rtl/matrix_csr_pkg.sv
// Shared definitions for the matrix-extension CSR front-end: addresses,
// field layouts, op encoding and the read-modify-write/legalisation helpers.
package matrix_csr_pkg;

  localparam logic [11:0] ADDR_XMRSTART = 12'h802;
  localparam logic [11:0] ADDR_XMCSR    = 12'h803;
  localparam logic [11:0] ADDR_XMSIZE   = 12'h804;
  localparam logic [11:0] ADDR_XMLENB   = 12'hCC0;
  localparam logic [11:0] ADDR_XRLENB   = 12'hCC1;
  localparam logic [11:0] ADDR_XMISA    = 12'hCC2;

  typedef enum logic [1:0] {
    CSR_RSVD = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic [28:0] rsvd;
    logic [1:0]  xmxrm;
    logic        xmsat;
  } xmcsr_t;

  typedef struct packed {
    logic [15:0] sizek;
    logic [7:0]  sizen;
    logic [7:0]  sizem;
  } xmsize_t;

  typedef struct packed {
    logic [23:0] rsvd;
    logic [7:0]  row_index;
  } xmrstart_t;

  function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old,
                                          input logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old | wdata;
      CSR_RC:  return old & ~wdata;
      default: return old;
    endcase
  endfunction

  // Clamp sizes to the physical tile and strip reserved bits before storage.
  function automatic logic [31:0] csr_legalise(input logic [11:0] addr, input logic [31:0] val,
                                               input int unsigned n_rows,
                                               input int unsigned kbytes);
    xmsize_t   s;
    xmcsr_t    c;
    xmrstart_t r;
    case (addr)
      ADDR_XMSIZE: begin
        s = xmsize_t'(val);
        if ({24'b0, s.sizem} > n_rows) s.sizem = 8'(n_rows);
        if ({24'b0, s.sizen} > n_rows) s.sizen = 8'(n_rows);
        if ({16'b0, s.sizek} > kbytes) s.sizek = 16'(kbytes);
        return 32'(s);
      end
      ADDR_XMCSR: begin
        c       = '0;
        c.xmsat = val[0];
        c.xmxrm = val[2:1];
        return 32'(c);
      end
      ADDR_XMRSTART: begin
        r           = '0;
        r.row_index = val[7:0] & 8'(n_rows - 1);
        return 32'(r);
      end
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/matrix_csr_regfile.sv
// Matrix CSR storage: software writes, hardware side-updates with their
// priorities, and the combinational read mux including read-only constants.
module matrix_csr_regfile
  import matrix_csr_pkg::*;
#(
  parameter int unsigned  RLEN      = 128,
  parameter logic [31:0]  XMISA_VAL = 32'h0000_0010,
  localparam int unsigned N_ROWS    = RLEN / 32,
  localparam int unsigned RSW       = $clog2(N_ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [11:0]     waddr,
  input  logic [31:0]     wdata,
  input  logic            sat_set,
  input  logic            rstart_we,
  input  logic [RSW-1:0]  rstart_wdata,
  input  logic [11:0]     raddr,
  output logic [31:0]     rdata,
  output logic            hit,
  output logic            ro,
  output logic [7:0]      cfg_sizem,
  output logic [7:0]      cfg_sizen,
  output logic [15:0]     cfg_sizek,
  output logic [1:0]      cfg_rm,
  output logic [RSW-1:0]  cfg_rstart
);

  xmcsr_t         csr_q, csr_d;
  xmsize_t        size_q;
  logic [RSW-1:0] rstart_q;

  // Sticky saturation is ORed after the software value so hardware wins a same-cycle clear.
  always_comb begin
    csr_d = csr_q;
    if (we && waddr == ADDR_XMCSR) csr_d = xmcsr_t'(wdata);
    csr_d.xmsat = csr_d.xmsat | sat_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_q    <= '0;
      size_q   <= '0;
      rstart_q <= '0;
    end else begin
      csr_q <= csr_d;
      if (we && waddr == ADDR_XMSIZE) size_q <= xmsize_t'(wdata);
      if (we && waddr == ADDR_XMRSTART) rstart_q <= wdata[RSW-1:0];
      else if (rstart_we)               rstart_q <= rstart_wdata;
    end
  end

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    ro    = 1'b0;
    case (raddr)
      ADDR_XMRSTART: rdata = 32'(rstart_q);
      ADDR_XMCSR:    rdata = 32'(csr_q);
      ADDR_XMSIZE:   rdata = 32'(size_q);
      ADDR_XMLENB: begin ro = 1'b1; rdata = 32'(N_ROWS * RLEN / 8); end
      ADDR_XRLENB: begin ro = 1'b1; rdata = 32'(RLEN / 8); end
      ADDR_XMISA:  begin ro = 1'b1; rdata = XMISA_VAL; end
      default:       hit = 1'b0;
    endcase
  end

  assign cfg_sizem  = size_q.sizem;
  assign cfg_sizen  = size_q.sizen;
  assign cfg_sizek  = size_q.sizek;
  assign cfg_rm     = csr_q.xmxrm;
  assign cfg_rstart = rstart_q;

endmodule

// File: rtl/matrix_csr_access.sv
// Matrix CSR front-end: request/response handshake and the FSM that defers
// tile-configuration writes until the matrix unit has drained.
module matrix_csr_access
  import matrix_csr_pkg::*;
#(
  parameter int unsigned  RLEN      = 128,
  parameter logic [31:0]  XMISA_VAL = 32'h0000_0010,
  localparam int unsigned N_ROWS    = RLEN / 32,
  localparam int unsigned RSW       = $clog2(N_ROWS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [11:0]     req_addr_i,
  input  logic [1:0]      req_op_i,
  input  logic [31:0]     req_wdata_i,
  input  logic            req_rs1_zero_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [31:0]     resp_rdata_o,
  output logic            resp_err_o,
  input  logic            mat_busy_i,
  input  logic            sat_set_i,
  input  logic            rstart_we_i,
  input  logic [RSW-1:0]  rstart_wdata_i,
  output logic [7:0]      cfg_sizem_o,
  output logic [7:0]      cfg_sizen_o,
  output logic [15:0]     cfg_sizek_o,
  output logic [1:0]      cfg_rm_o,
  output logic [RSW-1:0]  cfg_rstart_o,
  output logic            cfg_update_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

  state_e      state;
  logic [11:0] lat_addr;
  csr_op_e     lat_op;
  logic [31:0] lat_wdata;
  logic        lat_rs1_zero;

  logic [11:0] cur_addr;
  csr_op_e     cur_op;
  logic [31:0] cur_wdata;
  logic        cur_rs1_zero;
  logic [31:0] old_val, new_val;
  logic        hit, ro, is_write, err, cfg_target;
  logic        accept, defer, commit, we;

  // The RMW datapath is shared: in DRAIN it operates on the latched request,
  // so the returned old value is whatever the CSR holds at commit time.
  always_comb begin
    if (state == DRAIN) begin
      cur_addr     = lat_addr;
      cur_op       = lat_op;
      cur_wdata    = lat_wdata;
      cur_rs1_zero = lat_rs1_zero;
    end else begin
      cur_addr     = req_addr_i;
      cur_op       = csr_op_e'(req_op_i);
      cur_wdata    = req_wdata_i;
      cur_rs1_zero = req_rs1_zero_i;
    end
  end

  assign new_val    = csr_legalise(cur_addr, csr_rmw(cur_op, old_val, cur_wdata), N_ROWS, RLEN / 8);
  assign is_write   = (cur_op == CSR_RW) || ((cur_op != CSR_RSVD) && !cur_rs1_zero);
  assign err        = (cur_op == CSR_RSVD) || !hit || (ro && is_write);
  assign cfg_target = (cur_addr == ADDR_XMSIZE) || (cur_addr == ADDR_XMCSR);

  assign req_ready_o  = (state == IDLE);
  assign resp_valid_o = (state == RESP);
  assign accept       = req_ready_o && req_valid_i;
  assign defer        = accept && !err && is_write && cfg_target && mat_busy_i;
  assign commit       = (accept && !defer) || (state == DRAIN && !mat_busy_i);
  assign we           = commit && !err && is_write;
  assign cfg_update_o = we && cfg_target && !rst_i;

  matrix_csr_regfile #(
    .RLEN      (RLEN),
    .XMISA_VAL (XMISA_VAL)
  ) u_regfile (
    .clk          (clk_i),
    .rst          (rst_i),
    .we           (we),
    .waddr        (cur_addr),
    .wdata        (new_val),
    .sat_set      (sat_set_i),
    .rstart_we    (rstart_we_i),
    .rstart_wdata (rstart_wdata_i),
    .raddr        (cur_addr),
    .rdata        (old_val),
    .hit          (hit),
    .ro           (ro),
    .cfg_sizem    (cfg_sizem_o),
    .cfg_sizen    (cfg_sizen_o),
    .cfg_sizek    (cfg_sizek_o),
    .cfg_rm       (cfg_rm_o),
    .cfg_rstart   (cfg_rstart_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_op       <= CSR_RSVD;
      lat_wdata    <= '0;
      lat_rs1_zero <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (defer) begin
            lat_addr     <= req_addr_i;
            lat_op       <= csr_op_e'(req_op_i);
            lat_wdata    <= req_wdata_i;
            lat_rs1_zero <= req_rs1_zero_i;
            state        <= DRAIN;
          end else begin
            resp_rdata_o <= err ? '0 : old_val;
            resp_err_o   <= err;
            state        <= RESP;
          end
        end
        DRAIN: if (!mat_busy_i) begin
          resp_rdata_o <= old_val;
          resp_err_o   <= 1'b0;
          state        <= RESP;
        end
        RESP: if (resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_csr_access.sv
// Directed self-checking bench for matrix_csr_access with RLEN=128 (N_ROWS=4).
module tb_matrix_csr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        req_rs1_zero;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mat_busy, sat_set, rstart_we;
  logic [1:0]  rstart_wdata;
  logic [7:0]  cfg_sizem, cfg_sizen;
  logic [15:0] cfg_sizek;
  logic [1:0]  cfg_rm;
  logic [1:0]  cfg_rstart;
  logic        cfg_update;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int upd_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

  matrix_csr_access #(.RLEN(128), .XMISA_VAL(32'h0000_0010)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_op_i       (req_op),
    .req_wdata_i    (req_wdata),
    .req_rs1_zero_i (req_rs1_zero),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mat_busy_i     (mat_busy),
    .sat_set_i      (sat_set),
    .rstart_we_i    (rstart_we),
    .rstart_wdata_i (rstart_wdata),
    .cfg_sizem_o    (cfg_sizem),
    .cfg_sizen_o    (cfg_sizen),
    .cfg_sizek_o    (cfg_sizek),
    .cfg_rm_o       (cfg_rm),
    .cfg_rstart_o   (cfg_rstart),
    .cfg_update_o   (cfg_update)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input logic z);
    req_valid = 1'b1; req_addr = a; req_op = op; req_wdata = wd; req_rs1_zero = z;
    #1;
    chk("req_ready_at_issue", 32'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_after_consume", 32'(resp_valid), 0);
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] rdata, input logic err);
    chk({tag, "_valid"}, 32'(resp_valid), 1);
    chk({tag, "_rdata"}, resp_rdata, rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(err));
    consume();
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = '0; req_op = '0; req_wdata = '0; req_rs1_zero = 0;
    resp_ready = 0; mat_busy = 0; sat_set = 0; rstart_we = 0; rstart_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_cfg_all", {cfg_sizek, cfg_sizen, cfg_sizem}, 0);
    chk("rst_cfg_update", 32'(cfg_update), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read-only lengths and ISA word
    issue(12'hCC0, 2'b10, 32'h0, 1'b1);
    chk("xmlenb_ready_low", 32'(req_ready), 0);
    expect_resp("xmlenb", 32'd64, 1'b0);
    issue(12'hCC1, 2'b10, 32'h0, 1'b1);
    expect_resp("xrlenb", 32'd16, 1'b0);
    issue(12'hCC2, 2'b11, 32'h0, 1'b1);
    expect_resp("xmisa", 32'h10, 1'b0);

    // xmsize write with saturation, matrix idle
    upd_base = upd_cnt;
    issue(12'h804, 2'b01, 32'h0100_0909, 1'b0);
    expect_resp("xmsize_rw", 32'h0, 1'b0);
    chk("sizem", 32'(cfg_sizem), 4);
    chk("sizen", 32'(cfg_sizen), 4);
    chk("sizek", 32'(cfg_sizek), 16);
    chk("xmsize_upd_cnt", 32'(upd_cnt - upd_base), 1);
    issue(12'h804, 2'b10, 32'hFFFF_FFFF, 1'b1);
    expect_resp("xmsize_read", 32'h0010_0404, 1'b0);

    // Deferred xmcsr write while matrix busy
    upd_base = upd_cnt;
    mat_busy = 1'b1;
    issue(12'h803, 2'b01, 32'h4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_ready_low", 32'(req_ready), 0);
    chk("drain_no_resp", 32'(resp_valid), 0);
    chk("drain_rm_old", 32'(cfg_rm), 0);
    chk("drain_no_upd", 32'(upd_cnt - upd_base), 0);
    mat_busy = 1'b0;
    #1;
    chk("drain_commit_pulse", 32'(cfg_update), 1);
    @(posedge clk); #1;
    chk("drain_rm_new", 32'(cfg_rm), 2);
    chk("drain_upd_cnt", 32'(upd_cnt - upd_base), 1);
    expect_resp("xmcsr_deferred", 32'h0, 1'b0);

    // Sticky saturation against software clear
    issue(12'h803, 2'b10, 32'h1, 1'b0);
    expect_resp("set_sat", 32'h4, 1'b0);
    sat_set = 1'b1;
    issue(12'h803, 2'b11, 32'h1, 1'b0);
    sat_set = 1'b0;
    expect_resp("rc_sat_vs_hw", 32'h5, 1'b0);
    issue(12'h803, 2'b10, 32'h0, 1'b1);
    expect_resp("sat_sticky", 32'h5, 1'b0);
    issue(12'h803, 2'b11, 32'h1, 1'b0);
    expect_resp("rc_sat_plain", 32'h5, 1'b0);
    issue(12'h803, 2'b10, 32'h0, 1'b1);
    expect_resp("sat_cleared", 32'h4, 1'b0);

    // Error cases leave state untouched
    upd_base = upd_cnt;
    issue(12'hCC1, 2'b01, 32'h5, 1'b0);
    expect_resp("ro_write_err", 32'h0, 1'b1);
    issue(12'h7FF, 2'b01, 32'h5, 1'b0);
    expect_resp("bad_addr_err", 32'h0, 1'b1);
    issue(12'h804, 2'b00, 32'hFF, 1'b0);
    expect_resp("op00_err", 32'h0, 1'b1);
    chk("err_sizem_kept", 32'(cfg_sizem), 4);
    chk("err_no_upd", 32'(upd_cnt - upd_base), 0);

    // xmrstart: hardware update, legalised write, software priority
    rstart_we = 1'b1; rstart_wdata = 2'd3;
    @(posedge clk); #1;
    rstart_we = 1'b0;
    chk("hw_rstart", 32'(cfg_rstart), 3);
    issue(12'h802, 2'b01, 32'h6, 1'b0);
    expect_resp("rstart_rw", 32'h3, 1'b0);
    chk("rstart_legal", 32'(cfg_rstart), 2);
    rstart_we = 1'b1; rstart_wdata = 2'd1;
    issue(12'h802, 2'b01, 32'h3, 1'b0);
    rstart_we = 1'b0;
    chk("rstart_sw_wins", 32'(cfg_rstart), 3);
    expect_resp("rstart_rw2", 32'h2, 1'b0);

    // Reset while a deferred write is pending
    mat_busy = 1'b1;
    issue(12'h804, 2'b01, 32'h0008_0202, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_resp_valid", 32'(resp_valid), 0);
    chk("mid_rst_cfg", {cfg_sizek, cfg_sizen, cfg_sizem}, 0);
    chk("mid_rst_rm_rstart", {28'b0, cfg_rm, cfg_rstart}, 0);
    chk("mid_rst_update", 32'(cfg_update), 0);
    @(posedge clk); #1;
    rst = 1'b0; mat_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_resp", 32'(resp_valid), 0);
    chk("post_rst_dropped", 32'(cfg_sizem), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
